anton_neopixel_frame_scheduler: RTL and testbench
=================================================

// Module: anton_neopixel_frame_scheduler
// PURPOSE
//  Frame sequencer for anton_neopixel_stream_logic; all control crosses at frame boundaries.
//  Turns software start/stop pulses into the regCtrlInit/regCtrlRun levels and the initSlow strobe.
//  Tracks frame boundaries from streamPixelOf/streamSyncOf to provide one-shot, loop and stop-at-boundary.
//  Reports busy, per-frame done pulse, frame count and an init-timeout error to the APB register block.
// PARAMETERS
//  FRAME_CNT_BITS  16   width of frameCount; wraps modulo 2^FRAME_CNT_BITS
//  INIT_TIMEOUT    64   clk6_4mhz cycles allowed in WAIT_INIT for initSlowDone
// PORTS
//  clk6_4mhz      in   1               only clock; all logic rising-edge
//  rst            in   1               asynchronous, active-high reset
//  cmdStart       in   1               1-cycle start pulse
//  cmdStop        in   1               1-cycle stop pulse
//  cfgLoop        in   1               1 = repeat frames until stopped
//  initSlowDone   in   1               stream logic finished init
//  streamPixelOf  in   1               last bit of last pixel sent
//  streamSyncOf   in   1               reset gap complete
//  initSlow       out  1               1-cycle init strobe to stream logic
//  ctrlInit       out  1               drives regCtrlInit
//  ctrlRun        out  1               drives regCtrlRun
//  busy           out  1               state != IDLE
//  frameDone      out  1               1-cycle pulse per completed frame
//  frameCount     out  FRAME_CNT_BITS  completed frames since reset
//  errInitTo      out  1               sticky init-timeout flag
// BEHAVIOUR
//  Reset (async): state=IDLE; every output 0; internal stopPending=0; timeout counter=0.
//  All outputs registered; state changes 1 cycle after the qualifying input.
//  IDLE:      ctrlInit=0, ctrlRun=0. On cmdStart: clear errInitTo, clear stopPending; go to INIT.
//  INIT:      exactly 1 cycle. initSlow=1, ctrlInit=1. Always go to WAIT_INIT.
//  WAIT_INIT: ctrlInit=1; timeout counter +1 per cycle.
//             initSlowDone -> RUN.
//             Counter == INIT_TIMEOUT-1 without done -> IDLE with errInitTo=1.
//  RUN:       ctrlInit=0, ctrlRun=1. On streamPixelOf -> GAP.
//  GAP:       ctrlRun=1 so stream logic counts its reset delay. On streamSyncOf:
//             frameDone=1 for 1 cycle; frameCount+1.
//             Continue (back to RUN, ctrlRun stays 1) if cfgLoop=1 and stopPending=0.
//             Otherwise go to IDLE; ctrlRun=0 from the same edge, so no transmit cycle leaks.
//  cmdStop in RUN/GAP: sets stopPending; frame always completes, stop is applied at streamSyncOf.
//  cmdStop in INIT/WAIT_INIT: abort to IDLE next cycle; no frameDone, no error.
//  cmdStop in IDLE: no effect.
//  cmdStart while busy: ignored.
//  cmdStart and cmdStop in the same cycle: stop wins; start is discarded.
//  cfgLoop is sampled only at streamSyncOf; mid-frame changes apply at the next boundary.
//  streamPixelOf/streamSyncOf outside RUN/GAP: ignored.
//  frameCount wraps all-ones -> 0 with no flag.
//  rst asserted mid-frame: immediate IDLE, ctrlRun=0, counts cleared.
// CONFIGURATION
//  ANTON_SCHED_REPEAT_EN defined:
//   - adds input cfgRepeat [7:0] and output repeatLeft [7:0].
//   - On cmdStart, repeatLeft <= cfgRepeat (0 loads as 1); decremented at each frameDone.
//   - With cfgLoop=0, the scheduler continues to RUN while repeatLeft after decrement != 0 and stopPending=0.
//   - cfgLoop=1 overrides the count; repeatLeft still decrements, saturating at 0.
//  ANTON_SCHED_REPEAT_EN undefined: no cfgRepeat/repeatLeft ports; cfgLoop=0 gives exactly one frame per start.
// TESTING
//  T1 cfgLoop=0, cmdStart, initSlowDone 3 cycles after initSlow, PixelOf, SyncOf
//     -> initSlow 1 cycle, 1 frameDone, frameCount=1, busy=0, ctrlRun=0 at SyncOf edge.
//  T2 cfgLoop=1, 4 frames, cmdStop mid-frame 3
//     -> frame 3 completes, frameCount=3, IDLE after the 3rd SyncOf; no 4th RUN.
//  T3 cmdStart, initSlowDone withheld
//     -> IDLE after 64 cycles, errInitTo=1; next cmdStart clears it.
//  T4 cmdStart+cmdStop same cycle in IDLE -> stays IDLE.
//     cmdStop in WAIT_INIT -> IDLE, frameDone never pulses.
//  T5 rst asserted during GAP
//     -> all outputs 0 asynchronously; frameCount=0.
//     cmdStart while busy -> ignored; no second initSlow.
//  T6 (REPEAT_EN) cfgRepeat=3, cfgLoop=0 -> 3 frameDone pulses, repeatLeft=0, IDLE.
//     cfgRepeat=0 -> 1 frame.

Source files
------------

// File: rtl/anton_neopixel_frame_scheduler.sv
// Frame sequencer for the neopixel stream logic: start/stop pulses become init/run levels, frames end at streamSyncOf.
// Optional ANTON_SCHED_REPEAT_EN adds a per-start frame repeat count (cfgRepeat/repeatLeft).
module anton_neopixel_frame_scheduler #(
   parameter int FRAME_CNT_BITS = 16,
   parameter int INIT_TIMEOUT   = 64
) (
   input  logic                      clk6_4mhz,
   input  logic                      rst,
   input  logic                      cmdStart,
   input  logic                      cmdStop,
   input  logic                      cfgLoop,
   input  logic                      initSlowDone,
   input  logic                      streamPixelOf,
   input  logic                      streamSyncOf,
`ifdef ANTON_SCHED_REPEAT_EN
   input  logic [7:0]                cfgRepeat,
   output logic [7:0]                repeatLeft,
`endif
   output logic                      initSlow,
   output logic                      ctrlInit,
   output logic                      ctrlRun,
   output logic                      busy,
   output logic                      frameDone,
   output logic [FRAME_CNT_BITS-1:0] frameCount,
   output logic                      errInitTo
);

   localparam int TO_BITS = $clog2(INIT_TIMEOUT + 1);
   localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(INIT_TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, INIT, WAIT_INIT, RUN, GAP} state_t;

   state_t                    state, stateNext;
   logic                      stopPending, stopPendingNext;
   logic [TO_BITS-1:0]        toCount, toCountNext;
   logic                      errNext;
   logic [FRAME_CNT_BITS-1:0] frameCountNext;
   logic                      frameEnd;
   logic                      continueFrame;
   logic                      startAccepted;

   assign frameEnd      = (state == GAP) && streamSyncOf;
   assign startAccepted = (state == IDLE) && cmdStart && !cmdStop;

   // A stop arriving on the boundary cycle itself also ends the sequence there.
`ifdef ANTON_SCHED_REPEAT_EN
   logic [7:0] repeatNext, repeatDec;
   assign repeatDec     = (repeatLeft == 8'd0) ? 8'd0 : repeatLeft - 8'd1;
   assign continueFrame = (cfgLoop || (repeatDec != 8'd0)) && !stopPending && !cmdStop;

   always_comb begin
      repeatNext = repeatLeft;
      if (startAccepted)
         repeatNext = (cfgRepeat == 8'd0) ? 8'd1 : cfgRepeat;
      else if (frameEnd)
         repeatNext = repeatDec;
   end
`else
   assign continueFrame = cfgLoop && !stopPending && !cmdStop;
`endif

   always_comb begin
      stateNext       = state;
      stopPendingNext = stopPending;
      toCountNext     = toCount;
      errNext         = errInitTo;
      frameCountNext  = frameCount;
      case (state)
         IDLE: begin
            toCountNext = '0;
            if (startAccepted) begin
               stateNext       = INIT;
               errNext         = 1'b0;
               stopPendingNext = 1'b0;
            end
         end
         INIT: begin
            toCountNext = '0;
            stateNext   = cmdStop ? IDLE : WAIT_INIT;
         end
         WAIT_INIT: begin
            if (cmdStop)
               stateNext = IDLE;
            else if (initSlowDone)
               stateNext = RUN;
            else if (toCount == TO_LAST) begin
               stateNext = IDLE;
               errNext   = 1'b1;
            end else
               toCountNext = toCount + TO_BITS'(1);
         end
         RUN: begin
            if (cmdStop)
               stopPendingNext = 1'b1;
            if (streamPixelOf)
               stateNext = GAP;
         end
         GAP: begin
            if (cmdStop)
               stopPendingNext = 1'b1;
            if (streamSyncOf) begin
               frameCountNext = frameCount + 1'b1;
               stateNext      = continueFrame ? RUN : IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they change on the same edge as the state.
   always_ff @(posedge clk6_4mhz or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         stopPending <= 1'b0;
         toCount     <= '0;
         initSlow    <= 1'b0;
         ctrlInit    <= 1'b0;
         ctrlRun     <= 1'b0;
         busy        <= 1'b0;
         frameDone   <= 1'b0;
         frameCount  <= '0;
         errInitTo   <= 1'b0;
`ifdef ANTON_SCHED_REPEAT_EN
         repeatLeft  <= 8'd0;
`endif
      end else begin
         state       <= stateNext;
         stopPending <= stopPendingNext;
         toCount     <= toCountNext;
         initSlow    <= (stateNext == INIT);
         ctrlInit    <= (stateNext == INIT) || (stateNext == WAIT_INIT);
         ctrlRun     <= (stateNext == RUN) || (stateNext == GAP);
         busy        <= (stateNext != IDLE);
         frameDone   <= frameEnd;
         frameCount  <= frameCountNext;
         errInitTo   <= errNext;
`ifdef ANTON_SCHED_REPEAT_EN
         repeatLeft  <= repeatNext;
`endif
      end
   end

endmodule

// File: tb/tb_anton_neopixel_frame_scheduler.sv
// Self-checking bench for anton_neopixel_frame_scheduler: constant vector table, directed corner sequences,
// then randomized traffic against a cycle-level behavioural model (ANTON_SCHED_REPEAT_EN adds a repeat test).
module tb_anton_neopixel_frame_scheduler;

   localparam int FCB = 5;
   localparam int TMO = 64;

   logic           clk6_4mhz = 1'b0;
   logic           rst = 1'b1;
   logic           cmdStart = 1'b0, cmdStop = 1'b0, cfgLoop = 1'b0;
   logic           initSlowDone = 1'b0, streamPixelOf = 1'b0, streamSyncOf = 1'b0;
   logic [7:0]     cfgRepeatTb = 8'd0;
   logic           initSlow, ctrlInit, ctrlRun, busy, frameDone, errInitTo;
   logic [FCB-1:0] frameCount;
`ifdef ANTON_SCHED_REPEAT_EN
   logic [7:0]     repeatLeft;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 clk6_4mhz = ~clk6_4mhz;

   anton_neopixel_frame_scheduler #(.FRAME_CNT_BITS(FCB), .INIT_TIMEOUT(TMO)) dut (
      .clk6_4mhz    (clk6_4mhz),
      .rst          (rst),
      .cmdStart     (cmdStart),
      .cmdStop      (cmdStop),
      .cfgLoop      (cfgLoop),
      .initSlowDone (initSlowDone),
      .streamPixelOf(streamPixelOf),
      .streamSyncOf (streamSyncOf),
`ifdef ANTON_SCHED_REPEAT_EN
      .cfgRepeat    (cfgRepeatTb),
      .repeatLeft   (repeatLeft),
`endif
      .initSlow     (initSlow),
      .ctrlInit     (ctrlInit),
      .ctrlRun      (ctrlRun),
      .busy         (busy),
      .frameDone    (frameDone),
      .frameCount   (frameCount),
      .errInitTo    (errInitTo)
   );

   // Behavioural model: initAge -1 = not initialising, 0 = strobe cycle, 1..TMO = waiting cycle number.
   int mInitAge, mFrames, mRepeat;
   bit mSending, mInGap, mStopPend, mErr, mDone;

   function void modelReset();
      mInitAge = -1; mFrames = 0; mRepeat = 0;
      mSending = 0; mInGap = 0; mStopPend = 0; mErr = 0; mDone = 0;
   endfunction

   function void modelStep();
      mDone = 0;
      if (mInitAge < 0 && !mSending) begin
         if (cmdStart && !cmdStop) begin
            mInitAge = 0; mErr = 0; mStopPend = 0;
            mRepeat = (cfgRepeatTb == 8'd0) ? 1 : int'(cfgRepeatTb);
         end
      end else if (mInitAge == 0) begin
         mInitAge = cmdStop ? -1 : 1;
      end else if (mInitAge > 0) begin
         if (cmdStop) mInitAge = -1;
         else if (initSlowDone) begin mInitAge = -1; mSending = 1; mInGap = 0; end
         else if (mInitAge == TMO) begin mInitAge = -1; mErr = 1; end
         else mInitAge++;
      end else begin
         if (cmdStop) mStopPend = 1;
         if (!mInGap) mInGap = streamPixelOf;
         else if (streamSyncOf) begin
            mDone = 1;
            mFrames++;
            if (mRepeat > 0) mRepeat--;
            if (!((cfgLoop || mRepeat != 0) && !mStopPend)) mSending = 0;
            mInGap = 0;
         end
      end
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, wanted %0d", name, act, exp);
      end
   endtask

   task automatic checkAll(input string tag);
      check({tag, " busy"},       busy,      (mInitAge >= 0) || mSending);
      check({tag, " initSlow"},   initSlow,  mInitAge == 0);
      check({tag, " ctrlInit"},   ctrlInit,  mInitAge >= 0);
      check({tag, " ctrlRun"},    ctrlRun,   mSending);
      check({tag, " frameDone"},  frameDone, mDone);
      check({tag, " errInitTo"},  errInitTo, mErr);
      check({tag, " frameCount"}, frameCount, mFrames % (1 << FCB));
   endtask

   task automatic cycle(input bit st, sp, lp, dn, po, so, input string tag);
      cmdStart = st; cmdStop = sp; cfgLoop = lp;
      initSlowDone = dn; streamPixelOf = po; streamSyncOf = so;
      @(posedge clk6_4mhz);
      modelStep();
      #1;
      checkAll(tag);
   endtask

   task automatic checkZero(input string tag);
      check({tag, " busy"},       busy,       0);
      check({tag, " initSlow"},   initSlow,   0);
      check({tag, " ctrlInit"},   ctrlInit,   0);
      check({tag, " ctrlRun"},    ctrlRun,    0);
      check({tag, " frameDone"},  frameDone,  0);
      check({tag, " errInitTo"},  errInitTo,  0);
      check({tag, " frameCount"}, frameCount, 0);
   endtask

   // Reset is raised mid-cycle so the zero check proves it acts without a clock edge.
   task automatic doReset(input string tag);
      #2;
      rst = 1'b1;
      cmdStart = 0; cmdStop = 0; cfgLoop = 0; initSlowDone = 0; streamPixelOf = 0; streamSyncOf = 0;
      #1;
      checkZero(tag);
      @(posedge clk6_4mhz);
      #1;
      rst = 1'b0;
      modelReset();
      $display("%s: reset applied", tag);
   endtask

   typedef struct {
      bit st, sp, lp, dn, po, so;
      bit eBusy, eInit, eRun, eSlow, eDone;
      int eCount;
   } vec_t;

   localparam int NV = 31;
   vec_t vec [NV];

   bit rSt, rSp, rLp, rDn, rPo, rSo, noDone;
   int n;

   initial begin
      //          st sp lp dn po so  busy init run slow done count
      vec[0]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
      vec[1]  = '{1, 0, 0, 0, 0, 0,  1, 1, 0, 1, 0, 0};
      vec[2]  = '{0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0};
      vec[3]  = '{0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0};
      vec[4]  = '{0, 0, 0, 1, 0, 0,  1, 0, 1, 0, 0, 0};
      vec[5]  = '{0, 0, 0, 0, 1, 0,  1, 0, 1, 0, 0, 0};
      vec[6]  = '{0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0};
      vec[7]  = '{0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 1};
      vec[8]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1};
      vec[9]  = '{0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 1};
      vec[10] = '{1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1};
      vec[11] = '{1, 0, 0, 0, 0, 0,  1, 1, 0, 1, 0, 1};
      vec[12] = '{0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1};
      vec[13] = '{1, 0, 0, 0, 0, 0,  1, 1, 0, 1, 0, 1};
      vec[14] = '{0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 1};
      vec[15] = '{0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1};
      vec[16] = '{1, 0, 1, 0, 0, 0,  1, 1, 0, 1, 0, 1};
      vec[17] = '{0, 0, 1, 0, 0, 0,  1, 1, 0, 0, 0, 1};
      vec[18] = '{0, 0, 1, 1, 0, 0,  1, 0, 1, 0, 0, 1};
      vec[19] = '{1, 0, 1, 0, 0, 0,  1, 0, 1, 0, 0, 1};
      vec[20] = '{0, 0, 1, 0, 0, 1,  1, 0, 1, 0, 0, 1};
      vec[21] = '{0, 0, 1, 0, 1, 0,  1, 0, 1, 0, 0, 1};
      vec[22] = '{0, 1, 1, 0, 0, 0,  1, 0, 1, 0, 0, 1};
      vec[23] = '{0, 0, 1, 0, 0, 1,  0, 0, 0, 0, 1, 2};
      vec[24] = '{1, 0, 1, 0, 0, 0,  1, 1, 0, 1, 0, 2};
      vec[25] = '{0, 0, 1, 0, 0, 0,  1, 1, 0, 0, 0, 2};
      vec[26] = '{0, 0, 1, 1, 0, 0,  1, 0, 1, 0, 0, 2};
      vec[27] = '{0, 0, 1, 0, 1, 0,  1, 0, 1, 0, 0, 2};
      vec[28] = '{0, 0, 1, 0, 0, 1,  1, 0, 1, 0, 1, 3};
      vec[29] = '{0, 0, 0, 0, 1, 0,  1, 0, 1, 0, 0, 3};
      vec[30] = '{0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 4};

      modelReset();
      repeat (2) @(posedge clk6_4mhz);
      #1;
      checkZero("reset");
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         cmdStart = vec[i].st; cmdStop = vec[i].sp; cfgLoop = vec[i].lp;
         initSlowDone = vec[i].dn; streamPixelOf = vec[i].po; streamSyncOf = vec[i].so;
         @(posedge clk6_4mhz);
         #1;
         check($sformatf("vec%0d busy", i),       busy,       vec[i].eBusy);
         check($sformatf("vec%0d ctrlInit", i),   ctrlInit,   vec[i].eInit);
         check($sformatf("vec%0d ctrlRun", i),    ctrlRun,    vec[i].eRun);
         check($sformatf("vec%0d initSlow", i),   initSlow,   vec[i].eSlow);
         check($sformatf("vec%0d frameDone", i),  frameDone,  vec[i].eDone);
         check($sformatf("vec%0d errInitTo", i),  errInitTo,  0);
         check($sformatf("vec%0d frameCount", i), frameCount, vec[i].eCount);
         $display("vec %0d: busy=%0b init=%0b run=%0b slow=%0b done=%0b count=%0d",
                  i, busy, ctrlInit, ctrlRun, initSlow, frameDone, frameCount);
      end

      // Looping frames with a stop raised during the third frame.
      doReset("T2");
      cycle(1, 0, 1, 0, 0, 0, "T2 start");
      cycle(0, 0, 1, 0, 0, 0, "T2 wait");
      cycle(0, 0, 1, 1, 0, 0, "T2 initdone");
      for (int f = 1; f <= 4 && busy; f++) begin
         if (f == 3) cycle(0, 1, 1, 0, 0, 0, "T2 stop");
         cycle(0, 0, 1, 0, 1, 0, "T2 pixel");
         cycle(0, 0, 1, 0, 0, 1, "T2 sync");
         $display("T2: frame %0d ended, frameCount=%0d busy=%0b", f, frameCount, busy);
      end
      check("T2 frames", frameCount, 3);
      check("T2 idle", busy, 0);

      // Init timeout, then a fresh start clears the sticky flag.
      cycle(1, 0, 0, 0, 0, 0, "T3 start");
      n = 0;
      while (busy && n < 200) begin
         cycle(0, 0, 0, 0, 0, 0, "T3 wait");
         n++;
      end
      check("T3 cycles to timeout", n, TMO + 1);
      check("T3 err set", errInitTo, 1);
      $display("T3: timeout after %0d cycles, errInitTo=%0b", n, errInitTo);
      cycle(1, 0, 0, 0, 0, 0, "T3 restart");
      check("T3 err cleared", errInitTo, 0);
      cycle(0, 1, 0, 0, 0, 0, "T3 abort");

      // Frame counter wrap in loop mode.
      doReset("wrap");
      cycle(1, 0, 1, 0, 0, 0, "wrap start");
      cycle(0, 0, 1, 0, 0, 0, "wrap wait");
      cycle(0, 0, 1, 1, 0, 0, "wrap initdone");
      for (int f = 0; f < 40; f++) begin
         cycle(0, 0, 1, 0, 1, 0, "wrap pixel");
         cycle(0, 0, 1, 0, 0, 1, "wrap sync");
      end
      cycle(0, 1, 1, 0, 0, 0, "wrap stop");
      cycle(0, 0, 1, 0, 1, 0, "wrap pixel");
      cycle(0, 0, 1, 0, 0, 1, "wrap sync");
      check("wrap count", frameCount, 41 % (1 << FCB));
      $display("wrap: 41 frames, frameCount=%0d", frameCount);

      // Start ignored while busy, then async reset in GAP.
      cycle(1, 0, 0, 0, 0, 0, "T5 start");
      cycle(0, 0, 0, 0, 0, 0, "T5 wait");
      cycle(0, 0, 0, 1, 0, 0, "T5 initdone");
      cycle(1, 0, 0, 0, 0, 0, "T5 busy start");
      check("T5 no second initSlow", initSlow, 0);
      cycle(0, 0, 0, 0, 1, 0, "T5 pixel");
      check("T5 in gap run", ctrlRun, 1);
      doReset("T5 async");

`ifdef ANTON_SCHED_REPEAT_EN
      cfgRepeatTb = 8'd3;
      cycle(1, 0, 0, 0, 0, 0, "T6 start");
      cycle(0, 0, 0, 0, 0, 0, "T6 wait");
      cycle(0, 0, 0, 1, 0, 0, "T6 initdone");
      n = 0;
      while (busy && n < 10) begin
         cycle(0, 0, 0, 0, 1, 0, "T6 pixel");
         cycle(0, 0, 0, 0, 0, 1, "T6 sync");
         n++;
      end
      check("T6 frames", frameCount, 3);
      check("T6 repeatLeft", repeatLeft, 0);
      check("T6 idle", busy, 0);
      cfgRepeatTb = 8'd0;
      cycle(1, 0, 0, 0, 0, 0, "T6b start");
      cycle(0, 0, 0, 0, 0, 0, "T6b wait");
      cycle(0, 0, 0, 1, 0, 0, "T6b initdone");
      cycle(0, 0, 0, 0, 1, 0, "T6b pixel");
      cycle(0, 0, 0, 0, 0, 1, "T6b sync");
      check("T6b frames", frameCount, 4);
      check("T6b idle", busy, 0);
      $display("T6: repeat frames counted %0d", frameCount);
      doReset("T6 end");
`endif

      noDone = 0;
      for (int i = 0; i < 4000; i++) begin
         if (i % 400 == 0) noDone = ($urandom_range(0, 3) == 0);
         rSt = ($urandom_range(0, 7) == 0);
         rSp = ($urandom_range(0, 59) == 0);
         rLp = ($urandom_range(0, 3) != 0);
         rDn = !noDone && ($urandom_range(0, 11) == 0);
         rPo = ($urandom_range(0, 4) == 0);
         rSo = ($urandom_range(0, 3) == 0);
         cycle(rSt, rSp, rLp, rDn, rPo, rSo, "rand");
         if (frameDone) $display("rand %0d: frame done, frameCount=%0d", i, frameCount);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
